// File: rtl/z80_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_pkg
//  Description : Shared types and constants for the Z80 bus bridge and any
//                other logic that classifies Z80 bus cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
package z80_bus_pkg;

  // Bridge transaction states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  // Classification of the current Z80 bus cycle
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    MEM_RD  = 3'd1,
    MEM_WR  = 3'd2,
    IO_RD   = 3'd3,
    IO_WR   = 3'd4,
    INTA    = 3'd5,
    REFRESH = 3'd6
  } cycle_class_t;

  // Value the CPU sees when nothing real answers (open bus)
  localparam logic [7:0] Z80_IDLE_DATA = 8'hFF;

  // True for the cycle classes that carry data from CPU to the port
  function automatic logic is_write_class(input cycle_class_t c);
    return (c == MEM_WR) || (c == IO_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_cycle_decode.sv
`default_nettype none
// ============================================================================
//  Module      : z80_cycle_decode
//  Description : Purely combinational Z80 strobe decoder. Maps the raw
//                control strobes onto a single cycle_class_t value.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_cycle_decode
  import z80_bus_pkg::*;
(
  input  logic         m1_n,
  input  logic         mreq_n,
  input  logic         iorq_n,
  input  logic         rd_n,
  input  logic         wr_n,
  input  logic         rfsh_n,
  output cycle_class_t cls
);

  // Strobe combinations are mutually exclusive on a legal bus; the order only
  // matters for illegal overlaps, where memory writes win.
  always_comb begin
    cls = NONE;
    if (!mreq_n && !wr_n) begin
      cls = MEM_WR;
    end else if (!mreq_n && !rd_n && rfsh_n) begin
      cls = MEM_RD;
    end else if (!mreq_n && !rfsh_n) begin
      cls = REFRESH;
    end else if (!iorq_n && !m1_n) begin
      cls = INTA;
    end else if (!iorq_n && !wr_n) begin
      cls = IO_WR;
    end else if (!iorq_n && !rd_n) begin
      cls = IO_RD;
    end
  end

endmodule
`default_nettype wire

// File: rtl/z80_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_bridge
//  Description : Turns qualifying Z80 bus cycles into single requests on a
//                valid/ack memory port, stretching the CPU with wait_n until
//                the port answers. Read data is held on di.
//                Optional: define Z80_IO_BRIDGE_EN to forward I/O cycles to
//                the port (mem_io = 1); otherwise I/O is handled locally.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_bus_bridge
  import z80_bus_pkg::*;
#(
  parameter logic [7:0] IDLE_DATA      = Z80_IDLE_DATA,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic        wait_n,
  output logic [7:0]  di,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err
);

  // A zero timeout still needs a 1-bit counter to keep the logic legal
  localparam int             CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  cycle_class_t      cls;
  logic              active;
  logic              local_fill;
  logic              cls_io;
  logic              timeout_hit;

  bus_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_io_q, mem_io_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        di_q, di_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  z80_cycle_decode u_decode (
    .m1_n   (m1_n),
    .mreq_n (mreq_n),
    .iorq_n (iorq_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .rfsh_n (rfsh_n),
    .cls    (cls)
  );

`ifdef Z80_IO_BRIDGE_EN
  // I/O cycles travel to the port like memory cycles
  assign active     = (cls == MEM_RD) || (cls == MEM_WR) || (cls == IO_RD) || (cls == IO_WR);
  assign local_fill = (cls == INTA);
  assign cls_io     = (cls == IO_RD) || (cls == IO_WR);
`else
  // I/O reads answer open-bus locally, I/O writes vanish, mem_io stays 0
  assign active     = (cls == MEM_RD) || (cls == MEM_WR);
  assign local_fill = (cls == INTA) || (cls == IO_RD);
  assign cls_io     = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_io_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      di_q        <= IDLE_DATA;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_io_q    <= mem_io_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      di_q        <= di_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state: one request per CPU cycle, released once the strobes drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (active) state_d = REQ;
      REQ:     if (mem_ack || timeout_hit) state_d = DONE;
      DONE:    if (!active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: latch on issue, capture read data or abort on timeout
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_io_d    = mem_io_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    di_d        = di_q;
    bus_err_d   = bus_err_q;
    cnt_d       = cnt_q;
    if (state_q == REQ) begin
      cnt_d = cnt_q + 1'b1;
      if (mem_ack) begin
        mem_req_d = 1'b0;
        if (!mem_we_q) di_d = mem_rdata;
      end else if (timeout_hit) begin
        mem_req_d = 1'b0;
        di_d      = IDLE_DATA;
        bus_err_d = 1'b1;
      end
    end else if (state_q == IDLE && active) begin
      mem_req_d   = 1'b1;
      mem_we_d    = is_write_class(cls);
      mem_io_d    = cls_io;
      mem_addr_d  = A;
      mem_wdata_d = dout;
      cnt_d       = '0;
    end else if (local_fill) begin
      di_d = IDLE_DATA;
    end
  end

  // The CPU is held in reset alongside the bridge, so never stall it then
  assign wait_n    = !(reset_n && active && (state_q != DONE));
  assign di        = di_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_io    = mem_io_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_bus_bridge
//  Description : Self-checking bench for z80_bus_bridge. A per-CPU-cycle
//                transaction model predicts the bridge outputs each clock;
//                directed bus cycles add hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_z80_bus_bridge;

  localparam int TO = 4;
`ifdef Z80_IO_BRIDGE_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  // Bus cycle kinds driven by the CPU stand-in
  localparam int K_IDLE = 0, K_MRD = 1, K_MWR = 2, K_IORD = 3, K_IOWR = 4, K_INTA = 5, K_RFSH = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  dout = 8'h00;
  logic        wait_n, mem_req, mem_we, mem_io, bus_err;
  logic [7:0]  di, mem_wdata;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata = 8'h00;
  logic        resp_ack = 1'b0, stray_ack = 1'b0;

  assign mem_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  z80_bus_bridge #(.IDLE_DATA(8'hFF), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .A(A), .dout(dout), .wait_n(wait_n), .di(di),
    .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Does the current CPU cycle need the memory port?
  function automatic logic b_active();
    return (!mreq_n && !rd_n && rfsh_n) || (!mreq_n && !wr_n) ||
           (IO_EN && !iorq_n && m1_n && (!rd_n || !wr_n));
  endfunction

  // Cycles that put open-bus data on di without a request
  function automatic logic b_fill();
    return (!iorq_n && !m1_n) || (!IO_EN && !iorq_n && m1_n && !rd_n);
  endfunction

  // Transaction model: one outstanding request per CPU cycle
  logic        m_pending, m_served, m_err, m_we, m_io;
  logic [7:0]  m_di, m_wdata;
  logic [15:0] m_addr;
  int          m_age;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pending = 0; m_served = 0; m_age = 0; m_di = 8'hFF; m_err = 0;
      m_addr = 16'h0; m_we = 0; m_io = 0; m_wdata = 8'h0;
    end else if (m_pending) begin
      m_age++;
      if (mem_ack) begin
        m_pending = 0; m_served = 1;
        if (!m_we) m_di = mem_rdata;
      end else if (m_age == TO) begin
        m_pending = 0; m_served = 1; m_di = 8'hFF; m_err = 1;
      end
    end else begin
      if (m_served) begin
        if (!b_active()) m_served = 0;
      end else if (b_active()) begin
        m_pending = 1; m_age = 0; m_addr = A; m_we = !wr_n;
        m_io = IO_EN && !iorq_n; m_wdata = dout;
      end
      if (!b_active() && b_fill()) m_di = 8'hFF;
    end
  end

  // Per-cycle comparison against the model, plus request pulse counting
  int   req_rises = 0;
  logic req_prev = 1'b0;
  always @(posedge clk) begin
    #2;
    if (reset_n) begin
      chk("wait_n", wait_n, !(b_active() && !m_served));
      chk("mem_req", mem_req, m_pending);
      chk("di", di, m_di);
      chk("bus_err", bus_err, m_err);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_io", mem_io, m_io);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (mem_req && !req_prev) req_rises++;
    req_prev = mem_req;
  end

  // Memory responder: ack on the ack_after-th cycle of a request (0 = never)
  int         ack_after = 0;
  int         rq_age = 0;
  logic [7:0] rd_val = 8'h00;
  always @(negedge clk) begin
    if (mem_req) begin
      rq_age++;
      resp_ack  = (ack_after != 0) && (rq_age == ack_after);
      mem_rdata = rd_val;
    end else begin
      rq_age   = 0;
      resp_ack = 1'b0;
    end
  end

  task automatic set_strobes(input int kind);
    m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
    case (kind)
      K_MRD:  begin mreq_n = 0; rd_n = 0; end
      K_MWR:  begin mreq_n = 0; wr_n = 0; end
      K_IORD: begin iorq_n = 0; rd_n = 0; end
      K_IOWR: begin iorq_n = 0; wr_n = 0; end
      K_INTA: begin iorq_n = 0; m1_n = 0; end
      K_RFSH: begin mreq_n = 0; rfsh_n = 0; end
      default: ;
    endcase
  endtask

  // One CPU bus cycle; returns the number of wait states seen
  task automatic cpu_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data,
                           input int ackn, input logic [7:0] rdv, output int waits);
    @(negedge clk);
    ack_after = ackn; rd_val = rdv; A = addr; dout = data;
    set_strobes(kind);
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (wait_n) break;
      waits++;
    end
    chk("wait_release", wait_n, 1'b1);
    @(negedge clk);
    set_strobes(K_IDLE);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int w, r0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_di", di, 8'hFF);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_wait", wait_n, 1'b1);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Memory read, ack on the 3rd request cycle
    cpu_cycle(K_MRD, 16'h2A50, 8'h00, 3, 8'hA5, w);
    chk("rd_waits", w, 3);
    chk("rd_di", di, 8'hA5);
    chk("rd_addr", mem_addr, 16'h2A50);
    chk("rd_we", mem_we, 1'b0);

    // Memory write, ack on the first request cycle
    r0 = req_rises;
    cpu_cycle(K_MWR, 16'h4000, 8'h3C, 1, 8'h99, w);
    chk("wr_waits", w, 1);
    chk("wr_pulses", req_rises - r0, 1);
    chk("wr_di", di, 8'hA5);
    chk("wr_wdata", mem_wdata, 8'h3C);
    chk("wr_we", mem_we, 1'b1);

    // Stray ack while idle is ignored
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    chk("stray_di", di, 8'hA5);
    chk("stray_req", mem_req, 1'b0);

    // Refresh: nothing happens
    r0 = req_rises;
    cpu_cycle(K_RFSH, 16'h0033, 8'h00, 1, 8'h11, w);
    chk("rfsh_waits", w, 0);
    chk("rfsh_pulses", req_rises - r0, 0);
    chk("rfsh_di", di, 8'hA5);

    // Interrupt acknowledge: open-bus data, no request
    cpu_cycle(K_INTA, 16'h00FF, 8'h00, 1, 8'h22, w);
    chk("inta_waits", w, 0);
    chk("inta_pulses", req_rises - r0, 0);
    chk("inta_di", di, 8'hFF);

    // Second read, ack on the 2nd cycle
    cpu_cycle(K_MRD, 16'h8001, 8'h00, 2, 8'h5A, w);
    chk("rd2_waits", w, 2);
    chk("rd2_di", di, 8'h5A);

    // I/O read of port 0x00FE
    r0 = req_rises;
    cpu_cycle(K_IORD, 16'h00FE, 8'h00, 2, 8'h77, w);
    chk("iord_waits", w, IO_EN ? 2 : 0);
    chk("iord_pulses", req_rises - r0, IO_EN ? 1 : 0);
    chk("iord_di", di, IO_EN ? 8'h77 : 8'hFF);
    chk("iord_io", mem_io, IO_EN);
    chk("iord_addr", mem_addr, IO_EN ? 16'h00FE : 16'h8001);

    // I/O write
    cpu_cycle(K_IOWR, 16'h10FE, 8'h81, 1, 8'h33, w);
    chk("iowr_waits", w, IO_EN ? 1 : 0);
    chk("iowr_wdata", mem_wdata, IO_EN ? 8'h81 : 8'h00);
    chk("iowr_di", di, IO_EN ? 8'h77 : 8'hFF);

    // Read that is never acknowledged: aborts after TO cycles
    r0 = req_rises;
    cpu_cycle(K_MRD, 16'hC000, 8'h00, 0, 8'h00, w);
    chk("to_waits", w, TO);
    chk("to_pulses", req_rises - r0, 1);
    chk("to_err", bus_err, 1'b1);
    chk("to_di", di, 8'hFF);

    // Reset in the middle of a pending request
    @(negedge clk);
    ack_after = 0; A = 16'hC100; dout = 8'h00;
    set_strobes(K_MRD);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("mid_req_before", mem_req, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_req", mem_req, 1'b0);
    chk("mid_err", bus_err, 1'b0);
    chk("mid_wait", wait_n, 1'b1);
    @(negedge clk);
    set_strobes(K_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal read after reset release
    cpu_cycle(K_MRD, 16'h0100, 8'h00, 1, 8'hC3, w);
    chk("post_waits", w, 1);
    chk("post_di", di, 8'hC3);
    chk("post_err", bus_err, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
